// File: rtl/quad_gen_if.sv
// quad_gen_if: request/status bundle between a paddle controller and the
// quadrature encoder emulator.
//
// Signals:
//   load      controller -> emulator  1-cycle strobe, captures target
//   target    controller -> emulator  requested position (WIDTH bits)
//   position  emulator -> controller  current emitted position
//   quadA     emulator -> controller  quadrature channel A
//   quadB     emulator -> controller  quadrature channel B
//   step      emulator -> controller  pulse in the cycle A/B change
//   busy      emulator -> controller  position has not yet reached target
//   done      emulator -> controller  pulse in the cycle the target is reached
//
// Modports:
//   master  the side that issues targets (CPU, attract logic, test bench)
//   slave   the emulator itself
interface quad_gen_if #(
    parameter int WIDTH = 10
);
    logic             load;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] position;
    logic             quadA;
    logic             quadB;
    logic             step;
    logic             busy;
    logic             done;

    modport master (
        output load,
        output target,
        input  position,
        input  quadA,
        input  quadB,
        input  step,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  target,
        output position,
        output quadA,
        output quadB,
        output step,
        output busy,
        output done
    );
endinterface

// File: rtl/quad_gen.sv
// quad_gen: quadrature encoder emulator.
//
// Walks an internal position counter one count at a time towards a loaded
// target and emits the matching quadA/quadB Gray sequence, one edge every
// PERIOD clocks. Drives the quadrature inputs of the pong paddle decoder.
//
// Parameters:
//   WIDTH     width of position/target
//   PERIOD    clocks between quadrature edges (2..255)
//   INIT      position after reset
//   LIMIT_LO  lowest reachable position (targets below clamp up to it)
//   LIMIT_HI  highest reachable position (targets above clamp down to it)
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, wins over load
//   bus    quad_gen_if slave modport (load/target in; position, quadA,
//          quadB, step, busy, done out)
module quad_gen #(
    parameter int WIDTH             = 10,
    parameter int unsigned PERIOD   = 4,
    parameter int unsigned INIT     = 0,
    parameter int unsigned LIMIT_LO = 0,
    parameter int unsigned LIMIT_HI = 1023
) (
    input  logic        clk,
    input  logic        reset,
    quad_gen_if.slave   bus
);

    localparam logic [7:0]       RELOAD   = 8'(PERIOD - 1);
    localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] LO_V     = WIDTH'(LIMIT_LO);
    localparam logic [WIDTH-1:0] HI_V     = WIDTH'(LIMIT_HI);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Registered state
    logic [WIDTH-1:0] position_q;
    logic [WIDTH-1:0] target_q;
    logic             quad_a_q;
    logic             quad_b_q;
    logic [7:0]       timer_q;
    logic             step_q;
    logic             done_q;

    // Next-state values
    logic [WIDTH-1:0] target_clamped;
    logic [WIDTH-1:0] target_next;
    logic [WIDTH-1:0] position_next;
    logic             quad_a_next;
    logic             quad_b_next;
    logic [7:0]       timer_next;
    logic             step_now;
    logic             dir_up;

    // Clamp the requested target into the reachable window so that stepping
    // can never carry position outside it.
    always_comb begin
        target_clamped = bus.target;
        if (bus.target < LO_V) begin
            target_clamped = LO_V;
        end else if (bus.target > HI_V) begin
            target_clamped = HI_V;
        end
    end

    // Step decision and the next phase/position.
    // Direction is taken from the current target_q every step, so a retarget
    // mid-move simply changes which way the next edge goes.
    // Up walks 00->10->11->01 (A takes ~B, B takes A); down is the reverse
    // (A takes B, B takes ~A). Only one channel changes per step, and the
    // up/down choice shows up as A_new ^ B_old, which is what the decoder reads.
    always_comb begin
        step_now      = (timer_q == 8'd0) && (position_q != target_q);
        dir_up        = target_q > position_q;
        position_next = position_q;
        quad_a_next   = quad_a_q;
        quad_b_next   = quad_b_q;
        target_next   = bus.load ? target_clamped : target_q;

        if (step_now) begin
            if (dir_up) begin
                position_next = position_q + ONE;
                quad_a_next   = ~quad_b_q;
                quad_b_next   = quad_a_q;
            end else begin
                position_next = position_q - ONE;
                quad_a_next   = quad_b_q;
                quad_b_next   = ~quad_a_q;
            end
        end
    end

    // Period timer: reloads on a step, counts down to zero and parks there.
    // Parking at zero while idle lets the first edge of a new move go out on
    // the very next clock after the load.
    always_comb begin
        timer_next = timer_q;
        if (step_now) begin
            timer_next = RELOAD;
        end else if (timer_q != 8'd0) begin
            timer_next = timer_q - 8'd1;
        end
    end

    // done compares against the target that will be in force after this
    // edge, so done and the fall of busy always appear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            position_q <= INIT_V;
            target_q   <= INIT_V;
            quad_a_q   <= 1'b0;
            quad_b_q   <= 1'b0;
            timer_q    <= 8'd0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            position_q <= position_next;
            target_q   <= target_next;
            quad_a_q   <= quad_a_next;
            quad_b_q   <= quad_b_next;
            timer_q    <= timer_next;
            step_q     <= step_now;
            done_q     <= step_now && (position_next == target_next);
        end
    end

    assign bus.position = position_q;
    assign bus.quadA    = quad_a_q;
    assign bus.quadB    = quad_b_q;
    assign bus.step     = step_q;
    assign bus.done     = done_q;
    assign bus.busy     = position_q != target_q;

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: self-checking bench for quad_gen.
//
// Two emulators run side by side: dut0 with the default window and PERIOD=4,
// dut1 with a narrowed window [16,500], INIT=240 and PERIOD=3. A behavioural
// reference (position/target integers, a phase index into the Gray table,
// and the cycle number of the last edge) and a paddle decoder model run
// alongside both.
module tb_quad_gen;

    localparam int W = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    quad_gen_if #(.WIDTH(W)) bus0 ();
    quad_gen_if #(.WIDTH(W)) bus1 ();

    quad_gen #(
        .WIDTH(W), .PERIOD(4), .INIT(0), .LIMIT_LO(0), .LIMIT_HI(1023)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    quad_gen #(
        .WIDTH(W), .PERIOD(3), .INIT(240), .LIMIT_LO(16), .LIMIT_HI(500)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int m_period [2] = '{4, 3};
    int m_init   [2] = '{0, 240};
    int m_lo     [2] = '{0, 16};
    int m_hi     [2] = '{1023, 500};
    int m_pos    [2] = '{0, 240};
    int m_tgt    [2] = '{0, 240};
    int m_phase  [2] = '{0, 0};
    int m_last   [2] = '{-1000, -1000};
    bit m_step   [2];
    bit m_done   [2];
    int cycle = 0;
    logic [1:0] gray_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Decoder model state
    int         dec_cnt  [2] = '{0, 240};
    logic [1:0] dec_prev [2];
    int         dec_illegal = 0;

    function automatic logic [W-1:0] obs_pos(int d);
        return (d == 0) ? bus0.position : bus1.position;
    endfunction

    function automatic logic [1:0] obs_ab(int d);
        return (d == 0) ? {bus0.quadA, bus0.quadB} : {bus1.quadA, bus1.quadB};
    endfunction

    function automatic logic obs_step(int d);
        return (d == 0) ? bus0.step : bus1.step;
    endfunction

    function automatic logic obs_done(int d);
        return (d == 0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic obs_busy(int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic get_load(int d);
        return (d == 0) ? bus0.load : bus1.load;
    endfunction

    function automatic int get_target(int d);
        return (d == 0) ? int'(bus0.target) : int'(bus1.target);
    endfunction

    function automatic int clamp_t(int d, int t);
        if (t < m_lo[d]) return m_lo[d];
        if (t > m_hi[d]) return m_hi[d];
        return t;
    endfunction

    task automatic set_load(int d, logic l, logic [W-1:0] t);
        if (d == 0) begin
            bus0.load   = l;
            bus0.target = t;
        end else begin
            bus1.load   = l;
            bus1.target = t;
        end
    endtask

    // Paddle decoder: direction of each change is A_new ^ B_old.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [1:0] ab;
            ab = obs_ab(d);
            if (reset) begin
                dec_cnt[d]  = m_init[d];
                dec_prev[d] = ab;
            end else if (ab !== dec_prev[d]) begin
                if (ab[1] != dec_prev[d][1] && ab[0] != dec_prev[d][0])
                    dec_illegal++;
                else if (ab[1] ^ dec_prev[d][0])
                    dec_cnt[d]++;
                else
                    dec_cnt[d]--;
                dec_prev[d] = ab;
            end
        end
    end

    // Advance one clock: update the reference at the rising edge, then settle
    // at the falling edge where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        cycle++;
        for (int d = 0; d < 2; d++) begin
            m_step[d] = 1'b0;
            m_done[d] = 1'b0;
            if (reset) begin
                m_pos[d]   = m_init[d];
                m_tgt[d]   = m_init[d];
                m_phase[d] = 0;
                m_last[d]  = -1000;
            end else begin
                if (m_pos[d] != m_tgt[d] && (cycle - m_last[d]) >= m_period[d]) begin
                    m_step[d] = 1'b1;
                    m_last[d] = cycle;
                    if (m_tgt[d] > m_pos[d]) begin
                        m_pos[d]++;
                        m_phase[d] = (m_phase[d] + 1) % 4;
                    end else begin
                        m_pos[d]--;
                        m_phase[d] = (m_phase[d] + 3) % 4;
                    end
                end
                if (get_load(d)) m_tgt[d] = clamp_t(d, get_target(d));
                m_done[d] = m_step[d] && (m_pos[d] == m_tgt[d]);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int steps;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs_pos(d) !== W'(m_init[d])) begin
                tests_failed++;
                $display("[TB] FAIL reset_pos dut%0d: got %0d expected %0d", d, obs_pos(d), m_init[d]);
            end
            tests_run++;
            if (obs_ab(d) !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL reset_ab dut%0d: got %b expected 00", d, obs_ab(d));
            end
            tests_run++;
            if (obs_busy(d) !== 1'b0 || obs_step(d) !== 1'b0 || obs_done(d) !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_flags dut%0d: got busy=%b step=%b done=%b expected 0,0,0",
                         d, obs_busy(d), obs_step(d), obs_done(d));
            end
        end
        steps = 0;
        repeat (20) begin
            tick();
            if (obs_step(0) === 1'b1) steps++;
            if (obs_step(1) === 1'b1) steps++;
        end
        tests_run++;
        if (steps != 0) begin
            tests_failed++;
            $display("[TB] FAIL idle_steps: got %0d expected 0", steps);
        end
    endtask

    task automatic test_up_move();
        set_load(0, 1'b1, 10'd3);
        tick();
        set_load(0, 1'b0, 10'd0);
        tests_run++;
        if (obs_busy(0) !== 1'b1 || obs_pos(0) !== 10'd0 || obs_step(0) !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL up_load: got busy=%b pos=%0d step=%b expected 1,0,0",
                     obs_busy(0), obs_pos(0), obs_step(0));
        end
        for (int i = 1; i <= 12; i++) begin
            logic [1:0] e_ab;
            int e_pos;
            tick();
            e_pos = (i < 5) ? 1 : (i < 9) ? 2 : 3;
            e_ab  = (i < 5) ? 2'b10 : (i < 9) ? 2'b11 : 2'b01;
            tests_run++;
            if (obs_pos(0) !== W'(e_pos) || obs_ab(0) !== e_ab) begin
                tests_failed++;
                $display("[TB] FAIL up_seq i=%0d: got pos=%0d ab=%b expected pos=%0d ab=%b",
                         i, obs_pos(0), obs_ab(0), e_pos, e_ab);
            end
            tests_run++;
            if (obs_step(0) !== (i == 1 || i == 5 || i == 9) || obs_done(0) !== (i == 9)
                || obs_busy(0) !== (i < 9)) begin
                tests_failed++;
                $display("[TB] FAIL up_flags i=%0d: got step=%b done=%b busy=%b expected %b,%b,%b",
                         i, obs_step(0), obs_done(0), obs_busy(0),
                         (i == 1 || i == 5 || i == 9), (i == 9), (i < 9));
            end
        end
    endtask

    task automatic test_down_move();
        set_load(0, 1'b1, 10'd1);
        tick();
        set_load(0, 1'b0, 10'd0);
        for (int i = 1; i <= 8; i++) begin
            logic [1:0] e_ab;
            int e_pos;
            tick();
            e_pos = (i < 5) ? 2 : 1;
            e_ab  = (i < 5) ? 2'b11 : 2'b10;
            tests_run++;
            if (obs_pos(0) !== W'(e_pos) || obs_ab(0) !== e_ab) begin
                tests_failed++;
                $display("[TB] FAIL down_seq i=%0d: got pos=%0d ab=%b expected pos=%0d ab=%b",
                         i, obs_pos(0), obs_ab(0), e_pos, e_ab);
            end
            tests_run++;
            if (obs_step(0) !== (i == 1 || i == 5) || obs_done(0) !== (i == 5)
                || obs_busy(0) !== (i < 5)) begin
                tests_failed++;
                $display("[TB] FAIL down_flags i=%0d: got step=%b done=%b busy=%b expected %b,%b,%b",
                         i, obs_step(0), obs_done(0), obs_busy(0),
                         (i == 1 || i == 5), (i == 5), (i < 5));
            end
        end
    endtask

    task automatic test_retarget();
        int dones;
        set_load(0, 1'b1, 10'd0);
        tick();
        set_load(0, 1'b0, 10'd0);
        repeat (8) tick();
        tests_run++;
        if (obs_pos(0) !== 10'd0 || obs_ab(0) !== 2'b00 || obs_busy(0) !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL retarget_start: got pos=%0d ab=%b busy=%b expected 0,00,0",
                     obs_pos(0), obs_ab(0), obs_busy(0));
        end
        dones = 0;
        set_load(0, 1'b1, 10'd10);
        tick();
        set_load(0, 1'b0, 10'd0);
        for (int i = 1; i <= 16; i++) begin
            logic [1:0] e_ab;
            int e_pos;
            if (i == 6) set_load(0, 1'b1, 10'd0);
            tick();
            if (i == 6) set_load(0, 1'b0, 10'd0);
            if (obs_done(0) === 1'b1) dones++;
            e_pos = (i < 5) ? 1 : (i < 9) ? 2 : (i < 13) ? 1 : 0;
            e_ab  = (i < 5) ? 2'b10 : (i < 9) ? 2'b11 : (i < 13) ? 2'b10 : 2'b00;
            tests_run++;
            if (obs_pos(0) !== W'(e_pos) || obs_ab(0) !== e_ab
                || obs_step(0) !== (i == 1 || i == 5 || i == 9 || i == 13)) begin
                tests_failed++;
                $display("[TB] FAIL retarget_seq i=%0d: got pos=%0d ab=%b step=%b expected pos=%0d ab=%b",
                         i, obs_pos(0), obs_ab(0), obs_step(0), e_pos, e_ab);
            end
        end
        tests_run++;
        if (dones != 1) begin
            tests_failed++;
            $display("[TB] FAIL retarget_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_clamp();
        int req   [2] = '{1000, 3};
        int exp_t [2] = '{500, 16};
        int steps;
        int dones;
        int busy_seen;
        for (int k = 0; k < 2; k++) begin
            int lo;
            int hi;
            int n;
            lo = 1023;
            hi = 0;
            dones = 0;
            n = 0;
            set_load(1, 1'b1, W'(req[k]));
            tick();
            set_load(1, 1'b0, 10'd0);
            while (obs_busy(1) === 1'b1 && n < 3000) begin
                tick();
                n++;
                if (int'(obs_pos(1)) < lo) lo = int'(obs_pos(1));
                if (int'(obs_pos(1)) > hi) hi = int'(obs_pos(1));
                if (obs_done(1) === 1'b1) dones++;
            end
            tests_run++;
            if (n >= 3000 || obs_pos(1) !== W'(exp_t[k])) begin
                tests_failed++;
                $display("[TB] FAIL clamp_final req=%0d: got pos=%0d after %0d cycles expected %0d",
                         req[k], obs_pos(1), n, exp_t[k]);
            end
            tests_run++;
            if (lo < 16 || hi > 500 || dones != 1) begin
                tests_failed++;
                $display("[TB] FAIL clamp_range req=%0d: got min=%0d max=%0d dones=%0d expected within 16..500, 1 done",
                         req[k], lo, hi, dones);
            end
        end
        // Load whose clamped value equals the current position.
        steps = 0;
        dones = 0;
        busy_seen = 0;
        set_load(1, 1'b1, 10'd0);
        tick();
        set_load(1, 1'b0, 10'd0);
        repeat (10) begin
            if (obs_busy(1) === 1'b1) busy_seen++;
            tick();
            if (obs_step(1) === 1'b1) steps++;
            if (obs_done(1) === 1'b1) dones++;
        end
        tests_run++;
        if (steps != 0 || dones != 0 || busy_seen != 0 || obs_pos(1) !== 10'd16) begin
            tests_failed++;
            $display("[TB] FAIL clamp_noop: got steps=%0d dones=%0d busy=%0d pos=%0d expected 0,0,0,16",
                     steps, dones, busy_seen, obs_pos(1));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int steps;
        n = 0;
        set_load(0, 1'b1, 10'd20);
        tick();
        set_load(0, 1'b0, 10'd0);
        while (obs_pos(0) !== 10'd5 && n < 100) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= 100) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_reach: got pos=%0d expected 5 within 100 cycles", obs_pos(0));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (obs_pos(0) !== 10'd0 || obs_ab(0) !== 2'b00 || obs_busy(0) !== 1'b0 || obs_step(0) !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_state: got pos=%0d ab=%b busy=%b step=%b expected 0,00,0,0",
                     obs_pos(0), obs_ab(0), obs_busy(0), obs_step(0));
        end
        steps = 0;
        repeat (20) begin
            tick();
            if (obs_step(0) === 1'b1) steps++;
        end
        tests_run++;
        if (steps != 0 || obs_pos(0) !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_after: got steps=%0d pos=%0d expected 0,0", steps, obs_pos(0));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 19) == 0)
                    set_load(d, 1'b1, W'($urandom_range(0, 1023)));
                else
                    set_load(d, 1'b0, W'($urandom_range(0, 1023)));
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (obs_pos(d) !== W'(m_pos[d]) || obs_ab(d) !== gray_ab[m_phase[d]]) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_state dut%0d c=%0d: got pos=%0d ab=%b expected pos=%0d ab=%b",
                             d, c, obs_pos(d), obs_ab(d), m_pos[d], gray_ab[m_phase[d]]);
                end
                tests_run++;
                if (obs_step(d) !== m_step[d] || obs_done(d) !== m_done[d]
                    || obs_busy(d) !== (m_pos[d] != m_tgt[d])) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_flags dut%0d c=%0d: got step=%b done=%b busy=%b expected %b,%b,%b",
                             d, c, obs_step(d), obs_done(d), obs_busy(d),
                             m_step[d], m_done[d], (m_pos[d] != m_tgt[d]));
                end
                tests_run++;
                if (obs_pos(d) !== W'(dec_cnt[d])) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_decode dut%0d c=%0d: got pos=%0d decoder=%0d",
                             d, c, obs_pos(d), dec_cnt[d]);
                end
            end
        end
        reset = 1'b0;
        set_load(0, 1'b0, 10'd0);
        set_load(1, 1'b0, 10'd0);
    endtask

    task automatic test_decoder();
        tests_run++;
        if (dec_illegal != 0) begin
            tests_failed++;
            $display("[TB] FAIL decoder_illegal: got %0d double-channel changes expected 0", dec_illegal);
        end
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs_pos(d) !== W'(dec_cnt[d])) begin
                tests_failed++;
                $display("[TB] FAIL decoder_count dut%0d: got pos=%0d decoder=%0d", d, obs_pos(d), dec_cnt[d]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_load(0, 1'b0, 10'd0);
        set_load(1, 1'b0, 10'd0);
        test_reset();
        test_up_move();
        test_down_move();
        test_retarget();
        test_clamp();
        test_reset_mid();
        test_random();
        test_decoder();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
